// File: rtl/dice_game_ctrl_if.sv
// Signal bundle between the two-player dice controller and its environment.
// The controller takes the slave side; the board/bench takes the master side.
interface dice_game_ctrl_if;
    logic       btn_a;
    logic       btn_b;
    logic [2:0] throw;
    logic       roll;
    logic       turn;
    logic [2:0] score_a;
    logic [2:0] score_b;
    logic       result_valid;
    logic [1:0] winner;
    logic [7:0] rounds;
    logic [2:0] dbg_state;

    modport master (
        output btn_a,
        output btn_b,
        output throw,
        input  roll,
        input  turn,
        input  score_a,
        input  score_b,
        input  result_valid,
        input  winner,
        input  rounds,
        input  dbg_state
    );

    modport slave (
        input  btn_a,
        input  btn_b,
        input  throw,
        output roll,
        output turn,
        output score_a,
        output score_b,
        output result_valid,
        output winner,
        output rounds,
        output dbg_state
    );
endinterface

// File: rtl/dice_game_ctrl.sv
// Two-player dice controller: alternates A/B turns on a shared dice, scores each throw, reports the winner.
// Optional macro DICE_CTRL_TIE_REROLL_EN: a tied round restarts at player A instead of being reported.
module dice_game_ctrl #(
    parameter int MIN_ROLL = 4
) (
    input  logic              clk,
    input  logic              rst,
    dice_game_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        IDLE_A = 3'd0,
        ROLL_A = 3'd1,
        CAPT_A = 3'd2,
        IDLE_B = 3'd3,
        ROLL_B = 3'd4,
        CAPT_B = 3'd5,
        RESULT = 3'd6
    } state_t;

    localparam logic [3:0] MIN_ROLL_4 = 4'(MIN_ROLL);

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_cnt;
    logic       r_roll;
    logic [2:0] r_score_a;
    logic [2:0] r_score_b;
    logic       r_valid;
    logic [1:0] r_winner;
    logic [7:0] r_rounds;

    logic [3:0] w_cnt_nxt;
    logic       w_roll_nxt;
    logic [2:0] w_score_a_nxt;
    logic [2:0] w_score_b_nxt;
    logic       w_valid_nxt;
    logic [1:0] w_winner_nxt;
    logic [7:0] w_rounds_nxt;
    logic       w_turn;

    logic [2:0] w_capt;
    logic       w_roll_done;
    logic       w_tie;
    logic       w_a_wins;

    // Faces 0 and 7 are not real dice faces; count them as a 1.
    assign w_capt      = (bus.throw == 3'd0 || bus.throw == 3'd7) ? 3'd1 : bus.throw;
    assign w_roll_done = (r_cnt >= MIN_ROLL_4);
    assign w_tie       = (r_score_a == w_capt);
    assign w_a_wins    = (r_score_a > w_capt);

    // State and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE_A;
            r_cnt     <= 4'd0;
            r_roll    <= 1'b0;
            r_score_a <= 3'd0;
            r_score_b <= 3'd0;
            r_valid   <= 1'b0;
            r_winner  <= 2'b00;
            r_rounds  <= 8'd0;
        end else begin
            r_state   <= w_next;
            r_cnt     <= w_cnt_nxt;
            r_roll    <= w_roll_nxt;
            r_score_a <= w_score_a_nxt;
            r_score_b <= w_score_b_nxt;
            r_valid   <= w_valid_nxt;
            r_winner  <= w_winner_nxt;
            r_rounds  <= w_rounds_nxt;
        end
    end

    // Next-state logic; each player's button is only looked at during its own turn.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE_A: if (bus.btn_a) w_next = ROLL_A;
            ROLL_A: if (!bus.btn_a && w_roll_done) w_next = CAPT_A;
            CAPT_A: w_next = IDLE_B;
            IDLE_B: if (bus.btn_b) w_next = ROLL_B;
            ROLL_B: if (!bus.btn_b && w_roll_done) w_next = CAPT_B;
`ifdef DICE_CTRL_TIE_REROLL_EN
            CAPT_B: w_next = w_tie ? IDLE_A : RESULT;
`else
            CAPT_B: w_next = RESULT;
`endif
            RESULT: if (bus.btn_a) w_next = IDLE_A;
            default: w_next = IDLE_A;
        endcase
    end

    // Output/datapath next values, computed from the current state and the chosen transition.
    always_comb begin
        w_cnt_nxt     = 4'd0;
        w_roll_nxt    = (w_next == ROLL_A) || (w_next == ROLL_B);
        w_score_a_nxt = r_score_a;
        w_score_b_nxt = r_score_b;
        w_valid_nxt   = (w_next == RESULT);
        w_winner_nxt  = r_winner;
        w_rounds_nxt  = r_rounds;
        w_turn        = (r_state == IDLE_B) || (r_state == ROLL_B) || (r_state == CAPT_B);

        // Counter starts at 1 on entry and saturates at 15 while the button is held.
        if (w_roll_nxt) begin
            if (r_state == ROLL_A || r_state == ROLL_B)
                w_cnt_nxt = (r_cnt == 4'd15) ? 4'd15 : r_cnt + 4'd1;
            else
                w_cnt_nxt = 4'd1;
        end

        case (r_state)
            CAPT_A: w_score_a_nxt = w_capt;
            CAPT_B: begin
                if (w_next == RESULT) begin
                    w_score_b_nxt = w_capt;
                    if (w_tie)
                        w_winner_nxt = 2'b11;
                    else if (w_a_wins)
                        w_winner_nxt = 2'b01;
                    else
                        w_winner_nxt = 2'b10;
                    if (r_rounds != 8'd255)
                        w_rounds_nxt = r_rounds + 8'd1;
                end else begin
                    w_score_a_nxt = 3'd0;
                    w_score_b_nxt = 3'd0;
                end
            end
            RESULT: if (w_next == IDLE_A) w_winner_nxt = 2'b00;
            default: ;
        endcase
    end

    assign bus.roll         = r_roll;
    assign bus.turn         = w_turn;
    assign bus.score_a      = r_score_a;
    assign bus.score_b      = r_score_b;
    assign bus.result_valid = r_valid;
    assign bus.winner       = r_winner;
    assign bus.rounds       = r_rounds;
    assign bus.dbg_state    = r_state;

endmodule

// File: tb/tb_dice_game_ctrl.sv
// Self-checking bench for dice_game_ctrl: cycle-by-cycle vector table plus directed multi-cycle sequences.
module tb_dice_game_ctrl;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  dice_game_ctrl_if bus ();

  dice_game_ctrl #(.MIN_ROLL(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ba;
    logic       bb;
    logic [2:0] thr;
    logic [2:0] st;
    logic       roll;
    logic       turn;
    logic [2:0] sa;
    logic [2:0] sb;
    logic       vld;
    logic [1:0] win;
    logic [7:0] rnd;
  } vec_t;

  localparam int NV = 31;
  vec_t vt [NV];

  function automatic vec_t mk(input logic r, input logic a, input logic b, input logic [2:0] t,
                              input logic [2:0] s, input logic rl, input logic tu,
                              input logic [2:0] sa, input logic [2:0] sb, input logic v,
                              input logic [1:0] w, input logic [7:0] n);
    vec_t x;
    x.rst = r; x.ba = a; x.bb = b; x.thr = t; x.st = s; x.roll = rl; x.turn = tu;
    x.sa = sa; x.sb = sb; x.vld = v; x.win = w; x.rnd = n;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] st, input logic rl, input logic tu,
                         input logic [2:0] sa, input logic [2:0] sb, input logic v,
                         input logic [1:0] w, input logic [7:0] n);
    chk({tag, " state"}, 32'(bus.dbg_state), 32'(st));
    chk({tag, " roll"}, 32'(bus.roll), 32'(rl));
    chk({tag, " turn"}, 32'(bus.turn), 32'(tu));
    chk({tag, " score_a"}, 32'(bus.score_a), 32'(sa));
    chk({tag, " score_b"}, 32'(bus.score_b), 32'(sb));
    chk({tag, " result_valid"}, 32'(bus.result_valid), 32'(v));
    chk({tag, " winner"}, 32'(bus.winner), 32'(w));
    chk({tag, " rounds"}, 32'(bus.rounds), 32'(n));
  endtask

  // One player's turn from its IDLE state: press for one cycle, minimum roll, capture.
  task automatic play_side(input bit side, input logic [2:0] t);
    bus.throw = t;
    if (side) bus.btn_b = 1'b1; else bus.btn_a = 1'b1;
    step();
    bus.btn_a = 1'b0;
    bus.btn_b = 1'b0;
    repeat (3) step();
    step();
    step();
  endtask

  task automatic play_round(input logic [2:0] ta, input logic [2:0] tb);
    play_side(1'b0, ta);
    play_side(1'b1, tb);
    bus.btn_a = 1'b1;
    step();
    bus.btn_a = 1'b0;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus.btn_a = 1'b0;
    bus.btn_b = 1'b0;
    bus.throw = 3'd0;

    //             rst a  b  thr   st rl tu sa sb v  win    rnd
    vt[0]  = mk(1, 0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    vt[1]  = mk(0, 0, 1, 3'd0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    vt[2]  = mk(0, 1, 0, 3'd0, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    vt[3]  = mk(0, 1, 0, 3'd0, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    vt[4]  = mk(0, 0, 0, 3'd0, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    vt[5]  = mk(0, 0, 1, 3'd0, 1, 1, 0, 0, 0, 0, 2'b00, 0);
    vt[6]  = mk(0, 0, 0, 3'd0, 2, 0, 0, 0, 0, 0, 2'b00, 0);
    vt[7]  = mk(0, 0, 0, 3'd5, 3, 0, 1, 5, 0, 0, 2'b00, 0);
    vt[8]  = mk(0, 1, 0, 3'd5, 3, 0, 1, 5, 0, 0, 2'b00, 0);
    vt[9]  = mk(0, 0, 1, 3'd3, 4, 1, 1, 5, 0, 0, 2'b00, 0);
    vt[10] = mk(0, 1, 0, 3'd3, 4, 1, 1, 5, 0, 0, 2'b00, 0);
    vt[11] = mk(0, 0, 0, 3'd3, 4, 1, 1, 5, 0, 0, 2'b00, 0);
    vt[12] = mk(0, 0, 0, 3'd3, 4, 1, 1, 5, 0, 0, 2'b00, 0);
    vt[13] = mk(0, 0, 0, 3'd3, 5, 0, 1, 5, 0, 0, 2'b00, 0);
    vt[14] = mk(0, 0, 0, 3'd3, 6, 0, 0, 5, 3, 1, 2'b01, 1);
    vt[15] = mk(0, 0, 1, 3'd3, 6, 0, 0, 5, 3, 1, 2'b01, 1);
    vt[16] = mk(0, 1, 0, 3'd0, 0, 0, 0, 5, 3, 0, 2'b00, 1);
    vt[17] = mk(0, 1, 0, 3'd0, 1, 1, 0, 5, 3, 0, 2'b00, 1);
    vt[18] = mk(0, 0, 0, 3'd0, 1, 1, 0, 5, 3, 0, 2'b00, 1);
    vt[19] = mk(0, 0, 0, 3'd0, 1, 1, 0, 5, 3, 0, 2'b00, 1);
    vt[20] = mk(0, 0, 0, 3'd0, 1, 1, 0, 5, 3, 0, 2'b00, 1);
    vt[21] = mk(0, 0, 0, 3'd0, 2, 0, 0, 5, 3, 0, 2'b00, 1);
    vt[22] = mk(0, 0, 0, 3'd7, 3, 0, 1, 1, 3, 0, 2'b00, 1);
    vt[23] = mk(0, 0, 1, 3'd0, 4, 1, 1, 1, 3, 0, 2'b00, 1);
    vt[24] = mk(0, 0, 0, 3'd0, 4, 1, 1, 1, 3, 0, 2'b00, 1);
    vt[25] = mk(0, 0, 0, 3'd0, 4, 1, 1, 1, 3, 0, 2'b00, 1);
    vt[26] = mk(0, 0, 0, 3'd0, 4, 1, 1, 1, 3, 0, 2'b00, 1);
    vt[27] = mk(0, 0, 0, 3'd0, 5, 0, 1, 1, 3, 0, 2'b00, 1);
    vt[28] = mk(0, 0, 0, 3'd6, 6, 0, 0, 1, 6, 1, 2'b10, 2);
    vt[29] = mk(0, 1, 0, 3'd0, 0, 0, 0, 1, 6, 0, 2'b00, 2);
    vt[30] = mk(0, 0, 0, 3'd0, 0, 0, 0, 1, 6, 0, 2'b00, 2);

    for (int i = 0; i < NV; i++) begin
      rst       = vt[i].rst;
      bus.btn_a = vt[i].ba;
      bus.btn_b = vt[i].bb;
      bus.throw = vt[i].thr;
      step();
      chk_all($sformatf("row%0d", i), vt[i].st, vt[i].roll, vt[i].turn, vt[i].sa,
              vt[i].sb, vt[i].vld, vt[i].win, vt[i].rnd);
    end

    // Long hold: roll stays high past 15 cycles and exits right after release.
    bus.btn_a = 1'b1;
    for (int k = 0; k < 17; k++) begin
      step();
      chk($sformatf("hold%0d roll", k), 32'(bus.roll), 32'd1);
    end
    bus.btn_a = 1'b0;
    step();
    chk("hold release state", 32'(bus.dbg_state), 32'd2);
    chk("hold release roll", 32'(bus.roll), 32'd0);
    bus.throw = 3'd2;
    step();
    chk("hold capture score_a", 32'(bus.score_a), 32'd2);

    // Reset in the middle of ROLL_B.
    bus.btn_b = 1'b1;
    step();
    bus.btn_b = 1'b0;
    step();
    chk("pre-reset state", 32'(bus.dbg_state), 32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_all("midroll rst", 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 8'd0);
    step();
    chk("post-reset state", 32'(bus.dbg_state), 32'd0);

    // Tie at 4/4.
    play_side(1'b0, 3'd4);
    play_side(1'b1, 3'd4);
`ifdef DICE_CTRL_TIE_REROLL_EN
    chk_all("tie", 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 2'b00, 8'd0);
`else
    chk_all("tie", 3'd6, 1'b0, 1'b0, 3'd4, 3'd4, 1'b1, 2'b11, 8'd1);
    bus.btn_a = 1'b1;
    step();
    bus.btn_a = 1'b0;
    chk("tie leave state", 32'(bus.dbg_state), 32'd0);
`endif

    // Round counter saturation.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int r = 1; r <= 256; r++) begin
      play_round(3'd5, 3'd3);
      if (r >= 254)
        chk($sformatf("rounds after %0d", r), 32'(bus.rounds), (r > 255) ? 32'd255 : 32'(r));
    end
    chk("sat state", 32'(bus.dbg_state), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
